alu_op_sequencer: RTL
=====================

# alu_op_sequencer

Parametrised successor to the vector processor's combinational ALU control decoder. It accepts one 5-bit `exec` word per operation through a valid/ready handshake and decodes it into the same ALU select fields. Vector-class operations are then issued to the ALU datapath as a sequence of `LANES`-wide beats covering `VLEN` elements, with a per-beat lane mask and multi-cycle spacing for division. It sits between the execute-stage control and the ALU/vector-ALU/summation datapath.

## Interface
Parameters:
- `LANES`, 4: elements processed per beat; must be ≥1.
- `VLEN`, 16: elements per vector; must be ≥1. `VLEN` need not be a multiple of `LANES`.
- `DIV_CYCLES`, 8: cycles the divider occupies per beat; must be ≥1.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `exec`, input, 5: bit 4 = `func`, bits 3:1 = `opcode`, bit 0 reserved and ignored.
- `in_valid`, input, 1: `exec` is valid.
- `in_ready`, output, 1: sequencer can accept an operation.
- `opALU`, output, 3: ALU operation select.
- `operALUe`, output, 1: enable the scalar ALU path.
- `operALUve`, output, 1: enable the vector-scalar ALU path.
- `operSum`, output, 1: enable the vector-vector sum path.
- `beat_valid`, output, 1: a beat is presented to the datapath.
- `beat_ready`, input, 1: the datapath accepts the beat.
- `elem_base`, output, max(1,$clog2(VLEN)): index of the first element in the current beat.
- `lane_mask`, output, `LANES`: active lanes in the current beat.
- `beat_last`, output, 1: the current beat is the final beat of the operation.
- `done`, output, 1: one-cycle pulse when an operation completes.
- `err`, output, 1: one-cycle pulse when an illegal op is received.

## Operation

**Decode** (captured on accept, held in registers until the next accept):
- `func`=1: `opALU`=111, all three enables 0. Class is scalar.
- `func`=0: `opALU`=`opcode`.
  - Opcodes 000, 010, 011: `operALUe`=1. Class is scalar.
  - Opcodes 001, 100, 110: `operALUve`=1. Class is vector.
  - Opcode 101: `operSum`=1. Class is vector.
  - Opcode 110 additionally sets the class to div.
  - Opcode 111 is illegal.

**Beat count:**
- Scalar: 1 beat, `lane_mask`=1 (lane 0 only), `elem_base`=0.
- Vector: NB = ceil(VLEN/LANES) beats.
  - Beat k has `elem_base`=k·LANES.
  - `lane_mask` is all ones, except the last beat when VLEN mod LANES ≠ 0; that beat sets only the low (VLEN mod LANES) bits.

**FSM states:** IDLE, ISSUE, DWAIT.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: register the decode.
    - Legal op: go to ISSUE with beat 0.
    - Illegal op: `err` pulses the next cycle, stay in IDLE, no beats, no `done`.
- ISSUE:
  - `beat_valid`=1. All beat fields are stable while `beat_ready`=0.
  - On handshake of a non-div beat: advance to the next beat, or, if last, go to IDLE.
  - On handshake of a div beat: go to DWAIT with counter = DIV_CYCLES−1. If DIV_CYCLES=1, behave as a non-div beat.
- DWAIT:
  - `beat_valid`=0. Counter decrements each cycle.
  - At 0: go to ISSUE with the next beat, or to IDLE if the completed beat was last.
- `done` is registered. It pulses in the first IDLE cycle after the final beat (or final DWAIT).
- `in_ready` is 0 in ISSUE and DWAIT. Operations are never overlapped.

## Timing
- Reset values:
  - State IDLE, so `in_ready`=1.
  - `beat_valid`, `beat_last`, `done`, `err`, `operALUe`, `operALUve`, `operSum` = 0.
  - `opALU`=000, `elem_base`=0, `lane_mask`=0.
- Reset has priority over all events. A reset mid-op abandons the operation with no `done`.
- Accept at cycle t gives the first beat at t+1.
- A scalar op with `beat_ready` held high takes: accept t, beat t+1, `done` and `in_ready` at t+2.
- A vector op with `beat_ready` held high finishes with `done` at t+1+NB.
- A div op adds DIV_CYCLES−1 idle cycles after every beat.
- Decode outputs are valid from t+1 and held through `done` until the next accept.
- `beat_last` is asserted together with `beat_valid` on the final beat only.

## Structure
- Package `alu_ctrl_pkg` holds:
  - the opcode localparams,
  - the op-class enum (SCALAR, VECTOR, DIV, ILLEGAL),
  - the FSM state enum,
  - the `exec` field positions.
- Sub-module `alu_op_decode` is purely combinational. It maps `exec` to `opALU`, the three enables and the op class, and is instantiated once ahead of the capture register.

## Test plan
Use LANES=4, VLEN=10, DIV_CYCLES=3 unless stated.
1. Reset, then `exec`=00100 (opcode 010) with `beat_ready`=1 → one beat with `opALU`=010, `operALUe`=1, `lane_mask`=0001, `beat_last`=1; `done` at accept+2.
2. `exec`=01010 (opcode 101) with `beat_ready`=1 → 3 beats with `elem_base` 0, 4, 8 and `lane_mask` 1111, 1111, 0011; `operSum`=1; `done` at accept+4.
3. `exec`=01100 (opcode 110) → beats at accept+1, +4, +7 with `beat_valid`=0 between them; `done` at accept+10.
4. Opcode 100 with `beat_ready` toggling 0,1,0,0,1,1 → every beat held stable until its handshake; `elem_base` never skips or repeats.
5. `exec`=01110 (illegal) → `err` pulses for 1 cycle, no `beat_valid`, no `done`, `in_ready` stays 1. `exec`=1xxxx → `opALU`=111 with all enables 0 and one beat.
6. Assert `rst` during beat 2 of a vector op → next cycle `in_ready`=1, `beat_valid`=0, `done`=0, and a new op is accepted normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU op sequencer: exec field positions, opcodes,
// op classes, FSM states and the decoded-control record.
package alu_ctrl_pkg;

    localparam int EXEC_FUNC_BIT = 4;
    localparam int EXEC_OPC_HI   = 3;
    localparam int EXEC_OPC_LO   = 1;

    localparam logic [2:0] OPC_000    = 3'b000;
    localparam logic [2:0] OPC_001    = 3'b001;
    localparam logic [2:0] OPC_010    = 3'b010;
    localparam logic [2:0] OPC_011    = 3'b011;
    localparam logic [2:0] OPC_100    = 3'b100;
    localparam logic [2:0] OPC_101    = 3'b101;
    localparam logic [2:0] OPC_110    = 3'b110;
    localparam logic [2:0] OPC_111    = 3'b111;
    localparam logic [2:0] OPALU_FUNC = 3'b111;

    typedef enum logic [1:0] {SCALAR, VECTOR, DIV, ILLEGAL} op_class_e;
    typedef enum logic [1:0] {IDLE, ISSUE, DWAIT} seq_state_e;

    typedef struct packed {
        logic [2:0] op_alu;
        logic       alu_e;
        logic       alu_ve;
        logic       sum;
        op_class_e  cls;
    } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational exec-word decoder: ALU select, path enables and op class.
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [4:0] exec,
    output dec_t       dec
);

    logic [2:0] opc;
    logic       unused_rsvd;

    assign opc         = exec[EXEC_OPC_HI:EXEC_OPC_LO];
    assign unused_rsvd = exec[0];

    always_comb begin
        dec     = '0;
        dec.cls = SCALAR;
        if (exec[EXEC_FUNC_BIT]) begin
            dec.op_alu = OPALU_FUNC;
        end else begin
            dec.op_alu = opc;
            case (opc)
                OPC_000, OPC_010, OPC_011: dec.alu_e = 1'b1;
                OPC_001, OPC_100: begin
                    dec.alu_ve = 1'b1;
                    dec.cls    = VECTOR;
                end
                OPC_110: begin
                    dec.alu_ve = 1'b1;
                    dec.cls    = DIV;
                end
                OPC_101: begin
                    dec.sum = 1'b1;
                    dec.cls = VECTOR;
                end
                default: dec.cls = ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one exec word at a time, registers its decode and issues the
// operation to the datapath as LANES-wide beats with divider spacing.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int VLEN       = 16,
    parameter int DIV_CYCLES = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [4:0]                               exec,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output logic [2:0]                               opALU,
    output logic                                     operALUe,
    output logic                                     operALUve,
    output logic                                     operSum,
    output logic                                     beat_valid,
    input  logic                                     beat_ready,
    output logic [((VLEN > 1) ? $clog2(VLEN) : 1)-1:0] elem_base,
    output logic [LANES-1:0]                         lane_mask,
    output logic                                     beat_last,
    output logic                                     done,
    output logic                                     err
);

    localparam int EW  = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam int CW  = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam int REM = VLEN % LANES;
    localparam logic [LANES-1:0] FULL_MASK = '1;
    // Partial tail beat keeps only the low VLEN mod LANES lanes.
    localparam logic [LANES-1:0] LAST_MASK = (REM == 0) ? FULL_MASK : (FULL_MASK >> (LANES - REM));
    localparam logic             ONE_BEAT  = (LANES >= VLEN);

    dec_t            dec_in, dec_q, dec_d;
    seq_state_e      state_q, state_d;
    logic [EW-1:0]   base_q, base_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            beat_done;
    logic            nxt_last;

    alu_op_decode u_dec (
        .exec (exec),
        .dec  (dec_in)
    );

    assign nxt_last = (32'(base_q) + 32'(2 * LANES)) >= 32'(VLEN);

    always_comb begin
        dec_d     = dec_q;
        state_d   = state_q;
        base_d    = base_q;
        mask_d    = mask_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        beat_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dec_d = dec_in;
                    if (dec_in.cls == ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        base_d  = '0;
                        if (dec_in.cls == SCALAR) begin
                            mask_d = LANES'(1);
                            last_d = 1'b1;
                        end else begin
                            mask_d = ONE_BEAT ? LAST_MASK : FULL_MASK;
                            last_d = ONE_BEAT;
                        end
                    end
                end
            end
            ISSUE: begin
                if (beat_ready) begin
                    if (dec_q.cls == DIV && DIV_CYCLES > 1) begin
                        state_d = DWAIT;
                        cnt_d   = CW'(DIV_CYCLES - 1);
                    end else begin
                        beat_done = 1'b1;
                    end
                end
            end
            DWAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) beat_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (beat_done) begin
            if (last_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = ISSUE;
                base_d  = base_q + EW'(LANES);
                mask_d  = nxt_last ? LAST_MASK : FULL_MASK;
                last_d  = nxt_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dec_q   <= '0;
            base_q  <= '0;
            mask_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            base_q  <= base_d;
            mask_q  <= mask_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign beat_valid = (state_q == ISSUE);
    assign beat_last  = beat_valid && last_q;
    assign opALU      = dec_q.op_alu;
    assign operALUe   = dec_q.alu_e;
    assign operALUve  = dec_q.alu_ve;
    assign operSum    = dec_q.sum;
    assign elem_base  = base_q;
    assign lane_mask  = mask_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
